// File: rtl/dcache_wb_pkg.sv
// Shared types and geometry for the direct-mapped write-back D-cache.
// State encodings, address field widths and field helpers.
package dcache_wb_pkg;

    localparam int NUM_BLOCKS      = 8;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int ADDR_W          = 30;
    localparam int OFF_W           = 2;
    localparam int IDX_W           = $clog2(NUM_BLOCKS);
    localparam int TAG_W           = ADDR_W - OFF_W - IDX_W;
    localparam int BADDR_W         = ADDR_W - OFF_W;
    localparam int BLK_W           = 128;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [OFF_W-1:0] off_t;
    typedef logic [BLK_W-1:0] blk_t;

    function automatic idx_t addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Pipeline-side and memory-side bundles of the D-cache.
// master drives requests, slave answers them.
interface dcache_proc_if;
    import dcache_wb_pkg::*;

    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic              proc_stall;
    logic [31:0]       proc_rdata;

    modport master (
        output proc_read, proc_write,
        output proc_addr, proc_wdata,
        input  proc_stall, proc_rdata
    );

    modport slave (
        input  proc_read, proc_write,
        input  proc_addr, proc_wdata,
        output proc_stall, proc_rdata
    );
endinterface

interface dcache_mem_if;
    import dcache_wb_pkg::*;

    logic               mem_read;
    logic               mem_write;
    logic [BADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]   mem_wdata;
    logic               mem_ready;
    logic [BLK_W-1:0]   mem_rdata;

    modport master (
        output mem_read, mem_write,
        output mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write,
        input  mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: comb read, word write, line fill.
// Only valid and dirty are cleared by reset.
module dcache_line_array
    import dcache_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  idx_t        idx,
    output logic        valid,
    output logic        dirty,
    output tag_t        tag,
    output blk_t        line,
    input  logic        wr_en,
    input  off_t        wr_off,
    input  logic [31:0] wr_data,
    input  logic        fill_en,
    input  tag_t        fill_tag,
    input  blk_t        fill_line
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    tag_t                  tag_q  [NUM_BLOCKS];
    blk_t                  data_q [NUM_BLOCKS];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign line  = data_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (wr_en) begin
            data_q[idx][{wr_off, 5'd0} +: 32] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back write-allocate D-cache.
// Hits finish in the request cycle; misses stall through WB/fill.
module dcache_wb
    import dcache_wb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    dcache_proc_if.slave  proc,
    dcache_mem_if.master  mem
);

    state_t state_q, state_d;

    logic               valid, dirty;
    tag_t               line_tag;
    blk_t               line;
    idx_t               idx;
    tag_t               req_tag;
    off_t               off;
    logic               req, hit, hit_now;
    logic               mem_read_q, mem_write_q;
    logic [BADDR_W-1:0] mem_addr_q;
    blk_t               mem_wdata_q;
    logic               rd_done, wb_done;
    logic               store_hit, fill;

    assign idx     = addr_idx(proc.proc_addr);
    assign req_tag = addr_tag(proc.proc_addr);
    assign off     = proc.proc_addr[OFF_W-1:0];
    assign req     = proc.proc_read | proc.proc_write;
    assign hit     = valid && (line_tag == req_tag);
    assign hit_now = (state_q == COMPARE) && hit;

    // ready only counts once the request is actually on the bus
    assign rd_done = mem_read_q && mem.mem_ready;
    assign wb_done = mem_write_q && mem.mem_ready;

    assign store_hit = !rst && hit_now && proc.proc_write;
    assign fill      = !rst && (state_q == ALLOCATE) && rd_done;

    dcache_line_array u_lines (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .valid     (valid),
        .dirty     (dirty),
        .tag       (line_tag),
        .line      (line),
        .wr_en     (store_hit),
        .wr_off    (off),
        .wr_data   (proc.proc_wdata),
        .fill_en   (fill),
        .fill_tag  (req_tag),
        .fill_line (mem.mem_rdata)
    );

    assign proc.proc_stall = !rst && req && !hit_now;
    assign proc.proc_rdata =
        (!rst && hit_now && proc.proc_read) ?
        line[{off, 5'd0} +: 32] : '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= COMPARE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COMPARE: begin
                if (req && !hit)
                    state_d = (valid && dirty) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                if (wb_done) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (rd_done) state_d = COMPARE;
            end
            default: state_d = COMPARE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_write_q <= (state_q == WRITEBACK) && !wb_done;
            mem_read_q  <= (state_q == ALLOCATE) && !rd_done;
            if (state_q == WRITEBACK) begin
                mem_addr_q  <= {line_tag, idx};
                mem_wdata_q <= line;
            end else if (state_q == ALLOCATE) begin
                mem_addr_q  <= proc.proc_addr[ADDR_W-1:OFF_W];
            end
        end
    end

    assign mem.mem_read  = mem_read_q;
    assign mem.mem_write = mem_write_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
